// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: opcodes, instruction field
// positions and fetch-stage state encodings.
// Optional feature macro: FETCH_HALT_EN. When it is defined, opcode 4'b1111
// halts fetch.
package risc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_RTYPE = 4'b0000;
  localparam logic [OPC_W-1:0] OP_LW    = 4'b0001;
  localparam logic [OPC_W-1:0] OP_SW    = 4'b0010;
  localparam logic [OPC_W-1:0] OP_ADDI  = 4'b0011;
  localparam logic [OPC_W-1:0] OP_BEQ   = 4'b0100;
  localparam logic [OPC_W-1:0] OP_BNE   = 4'b0101;
  localparam logic [OPC_W-1:0] OP_JMP   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'b1111;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // REQ: request out; DRAIN: squashed request still outstanding;
  // HOLD: pending buffer full, no request; HALT: fetch stopped until reset.
  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // True when the word is a halt instruction and the halt feature is built in.
  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return HALT_EN && (word[OPC_MSB:OPC_LSB] == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Redirect decision and next-PC generation for the fetch stage.
// Ports:
//   pc          current fetch PC
//   ex_*        execute-stage branch/jump resolution
//   redirect_c  execute requests a PC redirect this cycle
//   target_c    redirect target (jump wins over branch)
//   pc_plus1_c  sequential next PC (wraps mod 2^ADDR_W)
module fetch_pc_gen #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned JMP_W  = 12
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              ex_valid,
  input  logic              ex_branch,
  input  logic              ex_bne,
  input  logic              ex_jump,
  input  logic              ex_zero,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] ex_imm,
  input  logic [JMP_W-1:0]  ex_jtarget,
  output logic              redirect_c,
  output logic [ADDR_W-1:0] target_c,
  output logic [ADDR_W-1:0] pc_plus1_c
);

  logic              take_branch;
  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] jump_tgt;

  // beq takes on zero, bne on non-zero.
  assign take_branch = ex_branch & (ex_zero ^ ex_bne);
  assign redirect_c  = ex_valid & (take_branch | ex_jump);

  assign branch_tgt = ex_pc + ADDR_W'(1) + ex_imm;
  // Jump keeps the upper PC bits of the executing instruction.
  assign jump_tgt   = {ex_pc[ADDR_W-1:JMP_W], ex_jtarget};
  assign target_c   = ex_jump ? jump_tgt : branch_tgt;

  assign pc_plus1_c = pc + ADDR_W'(1);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem
// request/ack handshake, buffers one instruction while decode is stalled and
// applies branch/jump redirects from execute.
// Optional feature macro: FETCH_HALT_EN (opcode 4'b1111 stops fetch).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr            fetch request, held stable until imem_ack
//   imem_ack/rdata           one-cycle response with instruction word
//   if_valid/if_instr/if_pc  instruction presented to decode
//   if_stall                 decode cannot accept, hold if_* outputs
//   ex_*                     execute-stage branch/jump resolution
//   halted                   fetch stopped on halt instruction
module fetch_unit
  import risc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(0),
  parameter int unsigned       JMP_W    = 12
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_stall,
  input  logic               ex_valid,
  input  logic               ex_branch,
  input  logic               ex_bne,
  input  logic               ex_jump,
  input  logic               ex_zero,
  input  logic [ADDR_W-1:0]  ex_pc,
  input  logic [ADDR_W-1:0]  ex_imm,
  input  logic [JMP_W-1:0]   ex_jtarget,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
  logic               if_valid_q, if_valid_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] pend_instr_q, pend_instr_d;
  logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
  logic               halted_q, halted_d;

  logic               redirect_c;
  logic [ADDR_W-1:0]  target_c;
  logic [ADDR_W-1:0]  pc_plus1_c;
  logic               ack_v;
  logic               out_free;

  fetch_pc_gen #(
    .ADDR_W (ADDR_W),
    .JMP_W  (JMP_W)
  ) u_pc_gen (
    .pc         (pc_q),
    .ex_valid   (ex_valid),
    .ex_branch  (ex_branch),
    .ex_bne     (ex_bne),
    .ex_jump    (ex_jump),
    .ex_zero    (ex_zero),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_jtarget (ex_jtarget),
    .redirect_c (redirect_c),
    .target_c   (target_c),
    .pc_plus1_c (pc_plus1_c)
  );

  // An ack only counts against a request we actually have on the bus; this
  // also drops a response that straddles a reset.
  assign ack_v    = imem_ack & imem_req_q;
  assign out_free = ~if_valid_q | ~if_stall;

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    pend_instr_d = pend_instr_q;
    pend_pc_d    = pend_pc_q;
    halted_d     = halted_q;

    case (state_q)
      ST_REQ: begin
        if (redirect_c) begin
          pc_d       = target_c;
          if_valid_d = 1'b0;
          // Request still out with no response: wait it out and discard it.
          if (imem_req_q && !ack_v) state_d = ST_DRAIN;
        end else if (ack_v) begin
          pc_d = pc_plus1_c;
          if (out_free) begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if (is_halt(imem_rdata)) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end
          end else begin
            pend_instr_d = imem_rdata;
            pend_pc_d    = pc_q;
            state_d      = ST_HOLD;
          end
        end else if (!if_stall) begin
          if_valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (redirect_c) begin
          pc_d       = target_c;
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
        end else if (!if_stall) begin
          if_instr_d = pend_instr_q;
          if_pc_d    = pend_pc_q;
          if_valid_d = 1'b1;
          if (is_halt(pend_instr_q)) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_REQ;
          end
        end
      end
      ST_DRAIN: begin
        if (redirect_c) pc_d = target_c;
        if (ack_v) state_d = ST_REQ;
      end
      ST_HALT: begin
      end
      default: state_d = ST_REQ;
    endcase

    imem_req_d  = (state_d == ST_REQ) || (state_d == ST_DRAIN);
    // The squashed request keeps its address until its ack arrives.
    imem_addr_d = (state_d == ST_DRAIN) ? imem_addr_q : pc_d;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_PC;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      pend_instr_q <= '0;
      pend_pc_q    <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      pend_instr_q <= pend_instr_d;
      pend_pc_q    <= pend_pc_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: an imem responder with programmable latency
// pushes expected {pc, instr} pairs, a monitor pops them as decode sees each
// new instruction, and the main sequence checks handshake/redirect corners.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_stall;
  logic        ex_valid, ex_branch, ex_bne, ex_jump, ex_zero;
  logic [15:0] ex_pc, ex_imm;
  logic [11:0] ex_jtarget;
  logic        halted;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat = 0;
  int   drop_req = 0;
  bit   spur_ack = 1'b0;
  bit   force_halt = 1'b0;
  bit   mon_en = 1'b1;

`ifdef FETCH_HALT_EN
  localparam logic EXP_HALT = 1'b1;
`else
  localparam logic EXP_HALT = 1'b0;
`endif

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_stall   (if_stall),
    .ex_valid   (ex_valid),
    .ex_branch  (ex_branch),
    .ex_bne     (ex_bne),
    .ex_jump    (ex_jump),
    .ex_zero    (ex_zero),
    .ex_pc      (ex_pc),
    .ex_imm     (ex_imm),
    .ex_jtarget (ex_jtarget),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {4'h1, a[11:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: acks after `lat` waiting cycles, records expectations.
  initial begin
    int cnt = 0;
    int drop_done = 0;
    exp_t e;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (spur_ack) begin
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
      end else if (imem_req && !rst) begin
        if (cnt >= lat) begin
          imem_ack   = 1'b1;
          imem_rdata = force_halt ? 16'hF000 : mem_word(imem_addr);
          cnt = 0;
          if (drop_req > drop_done) begin
            drop_done++;
          end else if (mon_en) begin
            e.pc    = imem_addr;
            e.instr = imem_rdata;
            sb_q.push_back(e);
          end
        end else begin
          cnt++;
        end
      end
    end
  end

  // Decode-side monitor: every newly presented instruction must be the next expected one.
  initial begin
    bit   prev_valid = 1'b0;
    bit   prev_cons  = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (if_valid && (prev_cons || !prev_valid)) begin
          n_tests++;
          assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL sb_unexpected: observed pc 'h%0h instr 'h%0h required none", if_pc, if_instr);
          end
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_pc", 32'(if_pc), 32'(e.pc));
            chk("sb_instr", 32'(if_instr), 32'(e.instr));
          end
        end
        prev_valid = if_valid;
        prev_cons  = if_valid && !if_stall;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; if_stall = 1'b0;
    ex_valid = 1'b0; ex_branch = 1'b0; ex_bne = 1'b0; ex_jump = 1'b0; ex_zero = 1'b0;
    ex_pc = 16'h0; ex_imm = 16'h0; ex_jtarget = 12'h0;
    repeat (3) tick();
    chk("rst_req", 32'(imem_req), 32'(0));
    chk("rst_valid", 32'(if_valid), 32'(0));
    chk("rst_instr", 32'(if_instr), 32'(0));
    chk("rst_pc", 32'(if_pc), 32'(0));
    chk("rst_halted", 32'(halted), 32'(0));

    // Zero-wait streaming.
    rst = 1'b0;
    tick();                                         // c1
    chk("c1_req", 32'(imem_req), 32'(1));
    chk("c1_addr", 32'(imem_addr), 32'(0));
    chk("c1_valid", 32'(if_valid), 32'(0));
    tick();                                         // c2
    chk("c2_valid", 32'(if_valid), 32'(1));
    chk("c2_pc", 32'(if_pc), 32'(0));
    chk("c2_addr", 32'(imem_addr), 32'(1));
    repeat (3) tick();                              // c5
    chk("c5_pc", 32'(if_pc), 32'(3));
    chk("c5_addr", 32'(imem_addr), 32'(4));

    // Slow memory: request held with stable address.
    lat = 3;
    for (int i = 0; i < 3; i++) begin               // c6..c8
      tick();
      chk("wait_req", 32'(imem_req), 32'(1));
      chk("wait_addr", 32'(imem_addr), 32'(4));
      chk("wait_valid", 32'(if_valid), 32'(0));
    end
    tick();                                         // c9
    chk("late_pc", 32'(if_pc), 32'(4));
    chk("late_valid", 32'(if_valid), 32'(1));
    chk("late_addr", 32'(imem_addr), 32'(5));
    lat = 0;
    tick();                                         // c10
    chk("c10_pc", 32'(if_pc), 32'(5));

    // Stall two cycles while a response lands in the pending buffer.
    if_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin               // c11, c12
      tick();
      chk("stall_req", 32'(imem_req), 32'(0));
      chk("stall_pc", 32'(if_pc), 32'(5));
      chk("stall_valid", 32'(if_valid), 32'(1));
    end
    if_stall = 1'b0;
    tick();                                         // c13
    chk("rel_pc", 32'(if_pc), 32'(6));
    chk("rel_valid", 32'(if_valid), 32'(1));
    chk("rel_req", 32'(imem_req), 32'(1));
    chk("rel_addr", 32'(imem_addr), 32'(7));
    tick();                                         // c14

    // beq taken with a simultaneous ack: 10 + 1 - 3 = 8.
    ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1; ex_pc = 16'd10; ex_imm = 16'hFFFD;
    drop_req++;
    tick();                                         // c15
    chk("beq_valid", 32'(if_valid), 32'(0));
    chk("beq_addr", 32'(imem_addr), 32'(8));
    chk("beq_req", 32'(imem_req), 32'(1));
    ex_valid = 1'b0;
    tick();                                         // c16
    chk("beq_pc", 32'(if_pc), 32'(8));

    // bne with zero set: not taken.
    ex_valid = 1'b1; ex_bne = 1'b1;
    tick();                                         // c17
    chk("bne_pc", 32'(if_pc), 32'(9));
    chk("bne_addr", 32'(imem_addr), 32'(10));
    chk("bne_valid", 32'(if_valid), 32'(1));
    ex_valid = 1'b0; ex_branch = 1'b0; ex_bne = 1'b0; ex_zero = 1'b0;

    // Jump while a slow request is outstanding: drain and drop stale data.
    lat = 3;
    tick();                                         // c18
    ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 16'h5123; ex_jtarget = 12'h0A0;
    tick();                                         // c19
    chk("drain_req", 32'(imem_req), 32'(1));
    chk("drain_addr", 32'(imem_addr), 32'(10));
    chk("drain_valid", 32'(if_valid), 32'(0));
    ex_valid = 1'b0; ex_jump = 1'b0;
    drop_req++;
    tick();                                         // c20
    chk("drain_addr2", 32'(imem_addr), 32'(10));
    lat = 0;
    tick();                                         // c21
    chk("jmp_addr", 32'(imem_addr), 32'(16'h50A0));
    chk("jmp_valid", 32'(if_valid), 32'(0));
    tick();                                         // c22
    chk("jmp_pc", 32'(if_pc), 32'(16'h50A0));

    // Jump to the top of the address space and wrap.
    ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 16'hF123; ex_jtarget = 12'hFFF;
    drop_req++;
    tick();                                         // c23
    chk("top_addr", 32'(imem_addr), 32'(16'hFFFF));
    chk("top_valid", 32'(if_valid), 32'(0));
    ex_valid = 1'b0; ex_jump = 1'b0;
    tick();                                         // c24
    chk("top_pc", 32'(if_pc), 32'(16'hFFFF));
    chk("wrap_addr", 32'(imem_addr), 32'(0));
    tick();                                         // c25
    chk("wrap_pc", 32'(if_pc), 32'(0));
    chk("wrap_addr2", 32'(imem_addr), 32'(1));

    // Reset with a request outstanding, then a stray ack before any request.
    rst = 1'b1; lat = 3;
    tick();                                         // c26
    chk("rst2_req", 32'(imem_req), 32'(0));
    chk("rst2_valid", 32'(if_valid), 32'(0));
    chk("rst2_pc", 32'(if_pc), 32'(0));
    chk("rst2_instr", 32'(if_instr), 32'(0));
    mon_en = 1'b0;
    tick();                                         // c27
    rst = 1'b0; spur_ack = 1'b1; lat = 0; force_halt = 1'b1;
    tick();                                         // c28
    spur_ack = 1'b0;
    chk("spur_valid", 32'(if_valid), 32'(0));
    chk("spur_req", 32'(imem_req), 32'(1));
    chk("spur_addr", 32'(imem_addr), 32'(0));

    // Opcode 4'b1111: halts only when the feature is built in.
    tick();                                         // c29
    chk("halt_instr", 32'(if_instr), 32'(16'hF000));
    chk("halt_pc", 32'(if_pc), 32'(0));
    chk("halt_valid", 32'(if_valid), 32'(1));
    chk("halt_flag", 32'(halted), 32'(EXP_HALT));
    chk("halt_req", 32'(imem_req), 32'(!EXP_HALT));
    force_halt = 1'b0;
    ex_valid = 1'b1; ex_jump = 1'b1; ex_pc = 16'h1234; ex_jtarget = 12'h555;
    for (int i = 0; i < 3; i++) begin               // c30..c32
      tick();
      ex_valid = 1'b0; ex_jump = 1'b0;
      chk("post_req", 32'(imem_req), 32'(!EXP_HALT));
      chk("post_flag", 32'(halted), 32'(EXP_HALT));
      chk("post_valid", 32'(if_valid), 32'(EXP_HALT ? 1 : (i == 0 ? 0 : 1)));
      chk("post_pc", 32'(if_pc), 32'(EXP_HALT ? 0 : (i == 0 ? 0 : 16'h1555 + i - 1)));
    end

    chk("sb_drained", 32'(sb_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
